mux4_scan_sequencer: RTL and testbench

- Upstream controller for the 4-to-1 single-bit mux stage. It drives the mux select lines sel1/sel0 and reads the mux output back.
- On a start request it steps through each enabled channel in ascending order. At each channel it waits a programmable settle time, then captures the mux output into a 4-bit sample register.
- It signals completion with a one-cycle done pulse. The result is a lab-level bit-scanner / parallel-capture unit.

---
 rtl/mux4_scan_sequencer.sv | 93 +++++++++
 tb/tb_mux4_scan_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer: steps a 4:1 mux through enabled channels, settles, captures each into sample.
// Define SCAN_CONTINUOUS_EN to re-run passes back to back until stop is seen in DONE.
module mux4_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] mask,
    input  logic       mux_out,
    output logic       sel1,
    output logic       sel0,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [3:0] LAST   = 4'(SETTLE_CYCLES - 1);
    logic [1:0] state, sel;
    logic [3:0] cnt, mask_q, hi;
    function automatic logic [1:0] lowest(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction
    assign {sel1, sel0} = sel;
    // channels strictly above the current one that are still enabled
    assign hi = mask_q & (4'b1110 << sel);
`ifndef SCAN_CONTINUOUS_EN
    logic unused_stop;
    assign unused_stop = stop;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= 2'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sample <= 4'd0;
            cnt    <= 4'd0;
            mask_q <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mask_q <= mask;
                    sample <= 4'd0;
                    cnt    <= 4'd0;
                    if (mask != 4'd0) begin
                        sel   <= lowest(mask);
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    sample[sel] <= mux_out;
                    cnt         <= 4'd0;
                    if (|hi) begin
                        sel   <= lowest(hi);
                        state <= SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
`ifdef SCAN_CONTINUOUS_EN
                    if (mask_q != 4'd0 && !stop) begin
                        sel   <= lowest(mask_q);
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// tb_mux4_scan_sequencer: scoreboard bench; each start pushes the expected per-cycle outputs.
module tb_mux4_scan_sequencer;
    localparam int S = 2;
    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic [3:0] sample;
    } exp_t;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, mux_out;
    logic [3:0] mask = 4'd0, data = 4'd0;
    logic       sel1, sel0, busy, done;
    logic [3:0] sample;
    exp_t       q[$];
    exp_t       e;
    logic [1:0] m_sel = 2'd0;
    logic [3:0] m_sample = 4'd0;
    logic       armed = 1'b0;
    int         errors = 0, checks = 0;
    mux4_scan_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
        .mux_out(mux_out), .sel1(sel1), .sel0(sel0), .busy(busy),
        .done(done), .sample(sample)
    );
    always #5 clk = ~clk;
    always_comb mux_out = data[{sel1, sel0}];
    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask
    // expected trace: SETTLE+SAMPLE cycles per enabled channel, then the done cycle
    task automatic push_scan(input logic [3:0] m);
        logic [3:0] s = 4'd0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k <= S; k++) q.push_back('{2'(ch), 1'b1, 1'b0, s});
                s[ch] = data[ch];
                m_sel = 2'(ch);
            end
        end
        q.push_back('{m_sel, 1'b0, 1'b1, s});
        m_sample = s;
    endtask
    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        check("drain", 8'(q.size()), 8'd0);
        repeat (2) @(posedge clk);
    endtask
    task automatic run_scan(input logic [3:0] m, input logic [3:0] d);
        @(negedge clk);
        data = d;
        mask = m;
        start = 1'b1;
        push_scan(m);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask
    always @(posedge clk) begin
        #1;
        if (armed) begin
            e = (q.size() != 0) ? q.pop_front() : '{m_sel, 1'b0, 1'b0, m_sample};
            check("sel", 8'({sel1, sel0}), 8'(e.sel));
            check("busy", 8'(busy), 8'(e.busy));
            check("done", 8'(done), 8'(e.done));
            check("sample", 8'(sample), 8'(e.sample));
        end
    end
    initial begin
        repeat (2) @(negedge clk);
        check("rst_sel", 8'({sel1, sel0}), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_sample", 8'(sample), 8'd0);
        rst = 1'b0;
        armed = 1'b1;
        repeat (3) @(negedge clk);
        run_scan(4'b1111, 4'b1101);
        run_scan(4'b0101, 4'b1101);
        run_scan(4'b0000, 4'b1111);
        // start pulses and mask changes while busy must not disturb the pass
        @(negedge clk);
        data = 4'b1000;
        mask = 4'b1000;
        start = 1'b1;
        push_scan(4'b1000);
        @(negedge clk);
        mask = 4'b0001;
        repeat (2) @(negedge clk);
        start = 1'b0;
        drain();
        // reset mid-SETTLE discards the pass
        @(negedge clk);
        mask = 4'b1000;
        start = 1'b1;
        push_scan(4'b1000);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        q.delete();
        m_sel = 2'd0;
        m_sample = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) run_scan(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
